// File: rtl/piso_readout_ctrl.sv
// Load/shift sequencer for the test chip PISO error-count chains; publishes whole words with valid/ack.
// Defining PISO_ACCUM_EN adds per-channel saturating accumulators on the acc port.
module piso_readout_ctrl #(
  parameter int N_CH      = 10,
  parameter int WIDTH     = 16,
  parameter int LOAD_CYC  = 1,
  parameter int MSB_FIRST = 0,
  parameter int ACC_W     = 32
) (
  input  logic                  shift_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clr,
  input  logic [N_CH-1:0]       q,
  input  logic                  data_ack,
  output logic                  load,
  output logic                  busy,
  output logic [N_CH*WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  overrun,
  output logic [15:0]           frame_cnt,
  output logic [N_CH*ACC_W-1:0] acc
);
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int LOAD_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [LOAD_W-1:0]     load_cnt_q, load_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [N_CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [N_CH*WIDTH-1:0] data_q, data_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  done;
  int                    bit_idx;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shadow_d   = shadow_q;
    load_d     = load_q;
    busy_d     = busy_q;
    done       = 1'b0;
    bit_idx    = (MSB_FIRST != 0) ? (WIDTH - 1 - int'(bit_cnt_q)) : int'(bit_cnt_q);
    unique case (state_q)
      IDLE: begin
        load_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = LOAD;
          busy_d     = 1'b1;
          load_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      LOAD: begin
        load_d = 1'b1;
        if (load_cnt_q == LOAD_W'(LOAD_CYC - 1)) begin
          state_d = SHIFT;
          load_d  = 1'b0;
        end else begin
          load_cnt_d = load_cnt_q + LOAD_W'(1);
        end
      end
      SHIFT: begin
        // Bit position decoded against constants so every shadow bit has a fixed index.
        for (int i = 0; i < N_CH; i++) begin
          for (int b = 0; b < WIDTH; b++) begin
            if (b == bit_idx) shadow_d[i*WIDTH + b] = q[i];
          end
        end
        if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
          load_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        load_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Publish path: a completing frame beats a same-edge ack; clr beats completion for counters.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    if (done) begin
      data_d      = shadow_d;
      valid_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (valid_q && !data_ack) overrun_d = 1'b1;
    end else if (data_ack) begin
      valid_d = 1'b0;
    end
    if (clr) begin
      frame_cnt_d = '0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge shift_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      load_q      <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef PISO_ACCUM_EN
  logic [ACC_W-1:0] acc_q   [N_CH];
  logic [ACC_W-1:0] acc_d   [N_CH];
  logic [ACC_W:0]   acc_sum [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      acc_sum[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(shadow_d[i*WIDTH +: WIDTH]);
      acc_d[i]   = acc_q[i];
      if (clr) begin
        acc_d[i] = '0;
      end else if (done) begin
        acc_d[i] = acc_sum[i][ACC_W] ? {ACC_W{1'b1}} : acc_sum[i][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge shift_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_acc_out
    assign acc[gi*ACC_W +: ACC_W] = acc_q[gi];
  end
`else
  assign acc = '0;
`endif

  assign load       = load_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_piso_readout_ctrl.sv
// Self-checking bench for piso_readout_ctrl: vector table, corner sequences and a random run
// checked against a frame-level model. Accumulator expectations follow PISO_ACCUM_EN.
module tb_piso_readout_ctrl;
  localparam int NCH     = 10;
  localparam int W       = 16;
  localparam int AW      = 16;
  localparam int ACC_MAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, clr, data_ack;
  logic [NCH-1:0]   q;
  logic             load, busy, data_valid, overrun;
  logic [15:0]      frame_cnt;
  logic [NCH*W-1:0] data;
  logic [NCH*AW-1:0] acc;

  logic        start2, clr2, ack2;
  logic [1:0]  q2;
  logic        load2, busy2, valid2, ovr2;
  logic [15:0] fcnt2;
  logic [15:0] data2;
  logic [15:0] acc2;

  piso_readout_ctrl #(.N_CH(NCH), .WIDTH(W), .LOAD_CYC(1), .MSB_FIRST(0), .ACC_W(AW)) dut (
    .shift_clk(clk), .rst(rst), .start(start), .clr(clr), .q(q), .data_ack(data_ack),
    .load(load), .busy(busy), .data(data), .data_valid(data_valid), .overrun(overrun),
    .frame_cnt(frame_cnt), .acc(acc)
  );

  piso_readout_ctrl #(.N_CH(2), .WIDTH(8), .LOAD_CYC(1), .MSB_FIRST(1), .ACC_W(8)) dut_msb (
    .shift_clk(clk), .rst(rst), .start(start2), .clr(clr2), .q(q2), .data_ack(ack2),
    .load(load2), .busy(busy2), .data(data2), .data_valid(valid2), .overrun(ovr2),
    .frame_cnt(fcnt2), .acc(acc2)
  );

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w9;
    bit          ack_done;
    bit          ack_after;
    bit          clr_done;
    bit          exp_valid;
    bit          exp_ovr;
    logic [15:0] exp_fcnt;
  } vec_t;

  vec_t vecs [7];

  int n_pass = 0;
  int n_total = 0;

  // Frame-level reference state
  logic [15:0] cur_w  [NCH];
  logic [15:0] m_data [NCH];
  int          m_acc  [NCH];
  bit          m_valid, m_ovr;
  logic [15:0] m_fcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_fcnt  = 16'd0;
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = 16'd0;
      m_acc[i]  = 0;
    end
  endfunction

  function automatic void model_clr();
    m_fcnt = 16'd0;
    m_ovr  = 1'b0;
    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
  endfunction

  function automatic void model_complete(input bit ack_done, input bit clr_done);
    if (clr_done) begin
      m_fcnt = 16'd0;
      m_ovr  = 1'b0;
    end else begin
      if (m_valid && !ack_done) m_ovr = 1'b1;
      m_fcnt = m_fcnt + 16'd1;
    end
    m_valid = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      m_data[i] = cur_w[i];
      if (clr_done) m_acc[i] = 0;
      else if (m_acc[i] + int'(cur_w[i]) > ACC_MAX) m_acc[i] = ACC_MAX;
      else m_acc[i] = m_acc[i] + int'(cur_w[i]);
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, data_valid, m_valid);
    chk({tag, ".overrun"}, overrun, m_ovr);
    chk({tag, ".fcnt"}, frame_cnt, m_fcnt);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s.data%0d", tag, i), data[i*W +: W], m_data[i]);
`ifdef PISO_ACCUM_EN
      chk($sformatf("%s.acc%0d", tag, i), acc[i*AW +: AW], m_acc[i]);
`else
      chk($sformatf("%s.acc%0d", tag, i), acc[i*AW +: AW], 0);
`endif
    end
  endtask

  // One readout from IDLE, streaming cur_w LSB-first; ends 1 time unit after the completion edge.
  task automatic run_frame(input bit ack_done, input bit clr_done, input bit rnd_start, input string tag);
    int lows;
    int busy_hi;
    lows = 0;
    busy_hi = 0;
    start = 1'b1;
    step();
    start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
    if (load === 1'b0) lows++;
    if (busy === 1'b1) busy_hi++;
    step();
    for (int b = 0; b < W; b++) begin
      if (load === 1'b0) lows++;
      if (busy === 1'b1) busy_hi++;
      for (int c = 0; c < NCH; c++) q[c] = cur_w[c][b];
      if (b == W - 1) begin
        start    = 1'b0;
        data_ack = ack_done;
        clr      = clr_done;
        chk({tag, ".pre_valid"}, data_valid, m_valid);
        chk({tag, ".pre_fcnt"}, frame_cnt, m_fcnt);
      end else if (rnd_start) begin
        start = 1'($urandom_range(0, 1));
      end
      step();
    end
    data_ack = 1'b0;
    clr      = 1'b0;
    q        = '0;
    if (load === 1'b0) lows++;
    if (busy === 1'b1) busy_hi++;
    chk({tag, ".load_low_cycles"}, lows, W);
    chk({tag, ".busy_cycles"}, busy_hi, W + 1);
    chk({tag, ".load_end"}, load, 1'b1);
    model_complete(ack_done, clr_done);
    $display("frame %s: ch0=%04h fcnt=%04h valid=%0b overrun=%0b", tag, data[W-1:0], frame_cnt,
             data_valid, overrun);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, cyc, t_prev, gap, lows2;
    bit ack_r, clr_r;
    logic [15:0] fc0;
    logic [7:0] p0, p1;

    vecs[0] = '{16'hA5C3, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[1] = '{16'h1234, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2};
    vecs[2] = '{16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[5] = '{16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[6] = '{16'hC3A5, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4};

    rst = 1'b1; start = 1'b0; clr = 1'b0; data_ack = 1'b0; q = '0;
    start2 = 1'b0; clr2 = 1'b0; ack2 = 1'b0; q2 = '0;
    model_reset();
    step();
    step();
    chk("reset.load", load, 1'b1);
    chk("reset.busy", busy, 1'b0);
    chk("reset.valid", data_valid, 1'b0);
    chk("reset.overrun", overrun, 1'b0);
    chk("reset.fcnt", frame_cnt, 16'd0);
    chk("reset.data_zero", |data, 1'b0);
    chk("reset.acc_zero", |acc, 1'b0);
    rst = 1'b0;
    step();

    // Abort in the middle of shifting: reset must drop the frame without publishing
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      q = NCH'($urandom) | NCH'(1);
      step();
    end
    chk("abort.pre_load", load, 1'b0);
    chk("abort.pre_busy", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort.load", load, 1'b1);
    chk("abort.busy", busy, 1'b0);
    chk("abort.valid", data_valid, 1'b0);
    chk("abort.data_zero", |data, 1'b0);
    q = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    model_reset();
    check_all("abort");
    $display("abort: reset mid-shift, load=%0b busy=%0b", load, busy);

    for (int k = 0; k < 7; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      for (int c = 0; c < NCH; c++) cur_w[c] = 16'd0;
      cur_w[0] = vecs[k].w0;
      cur_w[9] = vecs[k].w9;
      run_frame(vecs[k].ack_done, vecs[k].clr_done, 1'b0, tag);
      if (vecs[k].ack_after) begin
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        m_valid = 1'b0;
      end
      chk({tag, ".tbl_valid"}, data_valid, vecs[k].exp_valid);
      chk({tag, ".tbl_overrun"}, overrun, vecs[k].exp_ovr);
      chk({tag, ".tbl_fcnt"}, frame_cnt, vecs[k].exp_fcnt);
      chk({tag, ".tbl_ch0"}, data[15:0], vecs[k].w0);
      chk({tag, ".tbl_ch9"}, data[159:144], vecs[k].w9);
      chk({tag, ".tbl_ch5"}, data[95:80], 16'd0);
      check_all(tag);
    end

    for (int n = 0; n < 40; n++) begin
      string tag;
      tag = $sformatf("rnd%0d", n);
      for (int c = 0; c < NCH; c++) cur_w[c] = 16'($urandom);
      ack_r = ($urandom_range(0, 3) == 0);
      clr_r = ($urandom_range(0, 7) == 0);
      run_frame(ack_r, clr_r, 1'b1, tag);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        data_ack = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 7) == 0);
        if (data_ack) m_valid = 1'b0;
        if (clr) model_clr();
        step();
        data_ack = 1'b0;
        clr = 1'b0;
      end
      check_all(tag);
    end

    // start held high with ack on every edge: completions every LOAD_CYC+WIDTH+1 cycles
    for (int c = 0; c < NCH; c++) cur_w[c] = 16'd0;
    q = '0;
    start = 1'b1;
    data_ack = 1'b1;
    cyc = 0;
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      fc0 = frame_cnt;
      waited = 0;
      while (frame_cnt === fc0 && waited < 40) begin
        step();
        cyc++;
        waited++;
      end
      chk($sformatf("b2b.timeout%0d", f), (waited < 40), 1'b1);
      if (f > 0) chk($sformatf("b2b.period%0d", f), cyc - t_prev, 18);
      t_prev = cyc;
      model_complete(1'b1, 1'b0);
    end
    start = 1'b0;
    data_ack = 1'b0;
    check_all("b2b");
    $display("b2b: three frames with start held, fcnt=%04h", frame_cnt);

    force dut.frame_cnt_q = 16'hFFFF;
    #2;
    release dut.frame_cnt_q;
    m_fcnt = 16'hFFFF;
    for (int c = 0; c < NCH; c++) cur_w[c] = 16'($urandom);
    run_frame(1'b0, 1'b0, 1'b0, "wrap");
    chk("wrap.fcnt_zero", frame_cnt, 16'h0000);
    check_all("wrap");

    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clr();
    for (int c = 0; c < NCH; c++) cur_w[c] = 16'd0;
    cur_w[0] = 16'hFFFF;
    run_frame(1'b1, 1'b0, 1'b0, "sat1");
    run_frame(1'b1, 1'b0, 1'b0, "sat2");
`ifdef PISO_ACCUM_EN
    chk("sat.acc0", acc[15:0], 16'hFFFF);
`else
    chk("sat.acc0", acc[15:0], 16'h0000);
`endif
    check_all("sat");
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clr();
    chk("clr.acc0", acc[15:0], 16'h0000);
    chk("clr.fcnt", frame_cnt, 16'h0000);
    chk("clr.valid_kept", data_valid, 1'b1);
    check_all("clr");
    $display("clr: fcnt=%04h acc0=%04h", frame_cnt, acc[15:0]);

    // MSB-first 8-bit, 2-channel instance
    p0 = 8'h81;
    p1 = 8'h3C;
    lows2 = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    if (load2 === 1'b0) lows2++;
    step();
    for (int b = 0; b < 8; b++) begin
      if (load2 === 1'b0) lows2++;
      q2[0] = p0[7-b];
      q2[1] = p1[7-b];
      step();
    end
    q2 = '0;
    if (load2 === 1'b0) lows2++;
    chk("msb.load_low_cycles", lows2, 8);
    chk("msb.ch0", data2[7:0], 8'h81);
    chk("msb.ch1", data2[15:8], 8'h3C);
    chk("msb.valid", valid2, 1'b1);
    chk("msb.fcnt", fcnt2, 16'd1);
    $display("msb: ch0=%02h ch1=%02h", data2[7:0], data2[15:8]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_readout_ctrl.md
# piso_readout_ctrl

Parametrised readout controller for the test chip's parallel-in/serial-out (PISO) error-count chains. It drives the chip's `load` strobe and collects `WIDTH` serial bits from each of `N_CH` channels. Completed words are published atomically, with a valid/ack handshake and a frame counter. It sits between the test-chip pins and the FPGA host/UART readout logic, and supersedes the fixed 10-channel, 16-bit, free-running capture.

## Interface
- `N_CH`, 10, number of serial channels (1–32)
- `WIDTH`, 16, bits per channel word (2–32)
- `LOAD_CYC`, 1, cycles `load` is held high after `start` before shifting (≥1)
- `MSB_FIRST`, 0, 0: first shifted bit is word bit 0; 1: first shifted bit is bit `WIDTH-1`
- `ACC_W`, 32, per-channel accumulator width (≥ `WIDTH`)

Ports:
- `shift_clk` in 1: sole clock; also clocks the chip PISO
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: readout request, sampled in IDLE only
- `clr` in 1: synchronous clear of `frame_cnt`, `overrun` and accumulators
- `q` in `N_CH`: serial data from the chip PISO outputs, bit i = channel i
- `data_ack` in 1: consumer acknowledge
- `load` out 1: registered; 1 = chip parallel load/hold, 0 = chip shift
- `busy` out 1: high in LOAD and SHIFT
- `data` out `N_CH*WIDTH`: channel i in `[i*WIDTH +: WIDTH]`
- `data_valid` out 1: new frame available
- `overrun` out 1: sticky, set when a frame completes while the previous one is unacknowledged
- `frame_cnt` out 16: completed frames, wraps
- `acc` out `N_CH*ACC_W`: channel i in `[i*ACC_W +: ACC_W]`

## Operation
- Reset values: `load`=1, `busy`=0, `data`=0, `data_valid`=0, `overrun`=0, `frame_cnt`=0, `acc`=0. The FSM resets to IDLE and all counters to 0.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: `load`=1. If `start`=1, go to LOAD.
  - LOAD: hold `load`=1 for `LOAD_CYC` cycles, then go to SHIFT and set `load`<=0.
  - SHIFT: on each edge, sample `q` into the shadow register at bit index `bit_cnt` (MSB_FIRST=0) or `WIDTH-1-bit_cnt` (MSB_FIRST=1).
  - After the `WIDTH`th sample, on that same edge: `data`<=shadow with the final bit merged, `data_valid`<=1, `frame_cnt`+=1, `load`<=1, state<=IDLE.
- `data` changes only on frame completion and never shows a partial frame.
- `start` in LOAD or SHIFT is ignored. There is no request queueing.
- Handshake: `data_valid` stays high until `data_ack`=1 is sampled, then clears on that edge.
  - Completion and ack on the same edge: `data_valid` stays 1 (new frame), and `overrun` is not set.
  - Completion while `data_valid`=1 with no ack that edge: `overrun`<=1 and `data` is overwritten.
- `data_ack` while `data_valid`=0 has no effect.
- `clr`: on the next edge, zeros `frame_cnt`, `overrun` and `acc`. It does not affect the FSM, `data` or `data_valid`. If `clr` coincides with a completion, `clr` wins for `frame_cnt`/`overrun`/`acc`.
- `frame_cnt` wraps 0xFFFF→0x0000.
- `rst` during LOAD or SHIFT aborts the frame: `load` returns to 1 immediately and there is no partial publish.

## Timing
- `start` sampled at edge E0. `load` falls after edge E0+`LOAD_CYC` and stays low for exactly `WIDTH` cycles.
- Samples are taken at edges E0+`LOAD_CYC`+1 … E0+`LOAD_CYC`+`WIDTH`.
- `data_valid` is high after edge E0+`LOAD_CYC`+`WIDTH` (17 edges for the defaults).
- Earliest next `start` is sampled one edge after completion. Minimum frame period is `LOAD_CYC`+`WIDTH`+1 cycles.
- `busy` is registered and high from after E0 through the last sample edge.

## Configuration
- Macro: `PISO_ACCUM_EN`.
- Defined: on each completion, `acc[i]` <= `acc[i]` + zero-extended word i. The sum saturates at 2^`ACC_W`−1 and never wraps. `clr` zeros it.
- Undefined: `acc` is tied to 0, `clr` affects only `frame_cnt` and `overrun`, and no accumulator logic is synthesised.

## Test plan
- Reset, then defaults. Pulse `start`; channel 0 streams the pattern for 0xA5C3 LSB-first and channel 9 streams 0x0001. Required: `load` is low for exactly 16 cycles, `data_valid` rises 17 edges after `start`, data ch0=0xA5C3, ch9=0x0001, `frame_cnt`=1.
- MSB_FIRST=1, WIDTH=8, N_CH=2, streams 0x81 and 0x3C. Required: words 0x81 and 0x3C, and `load` is low for 8 cycles.
- Two frames with no ack. Required: `overrun`=1 after the second completion and `data` holds the second frame. Repeat with `data_ack` on the completion edge: `overrun` stays 0 and `data_valid` stays 1.
- Assert `rst` at the 5th SHIFT sample. Required: `load`=1 and `busy`=0 asynchronously, `data`/`data_valid` stay 0, and the next full frame captures correctly.
- `start` held high continuously. Required: back-to-back frames every 18 cycles with defaults. Preload `frame_cnt`=0xFFFF via 65535 frames (or a force), and one more frame gives 0x0000.
- With `PISO_ACCUM_EN`, ACC_W=16, ch0 word 0xFFFF for two frames. Required: `acc[0]` saturates at 0xFFFF, then `clr` gives 0. Without the macro, `acc`=0 throughout.
